// File: rtl/invtlb_walker.sv
// INVTLB sequencer: walks every tlb entry, clears the ones matching the op's rule, flags undefined ops.
// Optional INVTLB_FAST_CLR_EN: ops 0/1/2 use the tlb's single-cycle fast-clear strobe instead of walking.
module invtlb_walker #(
  parameter int unsigned TLBNUM           = 16,
  parameter int unsigned TLBNUM_IDX_WIDTH = (TLBNUM > 1) ? $clog2(TLBNUM) : 1
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [4:0]                  req_op,
  input  logic [9:0]                  req_asid,
  input  logic [18:0]                 req_vppn,
  output logic                        busy,
  output logic                        done,
  output logic                        ine,
  output logic [TLBNUM_IDX_WIDTH-1:0] r_index,
  input  logic                        r_e,
  input  logic [18:0]                 r_vppn,
  input  logic [5:0]                  r_ps,
  input  logic [9:0]                  r_asid,
  input  logic                        r_g,
  input  logic [19:0]                 r_ppn0,
  input  logic [1:0]                  r_plv0,
  input  logic [1:0]                  r_mat0,
  input  logic                        r_d0,
  input  logic                        r_v0,
  input  logic [19:0]                 r_ppn1,
  input  logic [1:0]                  r_plv1,
  input  logic [1:0]                  r_mat1,
  input  logic                        r_d1,
  input  logic                        r_v1,
  output logic                        we,
  output logic [TLBNUM_IDX_WIDTH-1:0] w_index,
  output logic                        w_e,
  output logic [18:0]                 w_vppn,
  output logic [5:0]                  w_ps,
  output logic [9:0]                  w_asid,
  output logic                        w_g,
  output logic [19:0]                 w_ppn0,
  output logic [1:0]                  w_plv0,
  output logic [1:0]                  w_mat0,
  output logic                        w_d0,
  output logic                        w_v0,
  output logic [19:0]                 w_ppn1,
  output logic [1:0]                  w_plv1,
  output logic [1:0]                  w_mat1,
  output logic                        w_d1,
  output logic                        w_v1,
  output logic                        invtlb_valid,
  output logic [4:0]                  invtlb_op
);

  localparam int unsigned IDX_W  = TLBNUM_IDX_WIDTH;
  localparam int unsigned VPPN_W = 19;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(TLBNUM - 1);
  localparam logic [VPPN_W-1:0] VPPN_ONES = '1;

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_FAST, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q;
  logic [4:0]          op_q;
  logic [9:0]          asid_q;
  logic [VPPN_W-1:0]   vppn_q;
  logic                done_q, ine_q;
  logic [4:0]          ps_sh;
  logic [VPPN_W-1:0]   vmask;
  logic                vm, asid_eq, hit;

  // Match rule: large pages ignore the low (ps-12) bits of the VPPN
  always_comb begin
    ps_sh = '0;
    if (r_ps >= 6'd31)     ps_sh = 5'd19;
    else if (r_ps > 6'd12) ps_sh = 5'(r_ps - 6'd12);
    vmask   = VPPN_ONES << ps_sh;
    vm      = ((r_vppn ^ vppn_q) & vmask) == '0;
    asid_eq = (r_asid == asid_q);
    case (op_q)
      5'd0, 5'd1: hit = 1'b1;
      5'd2:       hit = r_g;
      5'd3:       hit = ~r_g;
      5'd4:       hit = ~r_g & asid_eq;
      5'd5:       hit = ~r_g & asid_eq & vm;
      5'd6:       hit = (r_g | asid_eq) & vm;
      default:    hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    busy      = 1'b1;
    we        = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          if (req_op > 5'd6) state_d = S_DONE;
`ifdef INVTLB_FAST_CLR_EN
          else if (req_op <= 5'd2) state_d = S_FAST;
`endif
          else state_d = S_WALK;
        end
      end
      S_WALK: begin
        we = r_e & hit;
        if (idx_q == LAST_IDX) state_d = S_DONE;
      end
      S_FAST:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      op_q    <= '0;
      asid_q  <= '0;
      vppn_q  <= '0;
      done_q  <= 1'b0;
      ine_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= (state_q == S_WALK && state_d == S_WALK) ? idx_q + IDX_W'(1) : '0;
      if (req_valid && req_ready) begin
        op_q   <= req_op;
        asid_q <= req_asid;
        vppn_q <= req_vppn;
      end
      done_q  <= (state_d == S_DONE);
      // Only an undefined op reaches DONE straight from IDLE
      ine_q   <= (state_d == S_DONE) && (state_q == S_IDLE);
    end
  end

`ifdef INVTLB_FAST_CLR_EN
  logic       inv_valid_q;
  logic [4:0] inv_op_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inv_valid_q <= 1'b0;
      inv_op_q    <= '0;
    end else begin
      inv_valid_q <= (state_d == S_FAST);
      inv_op_q    <= (state_d == S_FAST && req_op == 5'd2) ? 5'd1 : 5'd0;
    end
  end

  assign invtlb_valid = inv_valid_q;
  assign invtlb_op    = inv_op_q;
`else
  assign invtlb_valid = 1'b0;
  assign invtlb_op    = '0;
`endif

  assign done    = done_q;
  assign ine     = ine_q;
  assign r_index = idx_q;
  assign w_index = idx_q;
  assign w_e     = 1'b0;
  assign w_vppn  = r_vppn;
  assign w_ps    = r_ps;
  assign w_asid  = r_asid;
  assign w_g     = r_g;
  assign w_ppn0  = r_ppn0;
  assign w_plv0  = r_plv0;
  assign w_mat0  = r_mat0;
  assign w_d0    = r_d0;
  assign w_v0    = r_v0;
  assign w_ppn1  = r_ppn1;
  assign w_plv1  = r_plv1;
  assign w_mat1  = r_mat1;
  assign w_d1    = r_d1;
  assign w_v1    = r_v1;

endmodule

// File: tb/tb_invtlb_walker.sv
// Bench for invtlb_walker: behavioural tlb memory, spec-level INVTLB model, per-cycle compare.
module tb_invtlb_walker;

  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic [9:0]  asid;
    logic        g;
    logic [19:0] ppn0;
    logic [19:0] ppn1;
    logic [1:0]  plv0, plv1, mat0, mat1;
    logic        d0, d1, v0, v1;
  } ent_t;

  logic clk = 1'b0;
  logic resetn;
  logic req_valid, req_ready;
  logic [4:0] req_op;
  logic [9:0] req_asid;
  logic [18:0] req_vppn;
  logic busy, done, ine, we, w_e, invtlb_valid;
  logic [3:0] r_index, w_index;
  logic [4:0] invtlb_op;
  logic r_e, r_g, r_d0, r_v0, r_d1, r_v1, w_g, w_d0, w_v0, w_d1, w_v1;
  logic [18:0] r_vppn, w_vppn;
  logic [5:0] r_ps, w_ps;
  logic [9:0] r_asid, w_asid;
  logic [19:0] r_ppn0, r_ppn1, w_ppn0, w_ppn1;
  logic [1:0] r_plv0, r_mat0, r_plv1, r_mat1, w_plv0, w_mat0, w_plv1, w_mat1;

  ent_t tlb [16];
  int   we_cnt;
  int   n_cmp = 0;
  int   n_bad = 0;

  invtlb_walker #(.TLBNUM(16)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_asid(req_asid), .req_vppn(req_vppn),
    .busy(busy), .done(done), .ine(ine), .r_index(r_index),
    .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps), .r_asid(r_asid), .r_g(r_g),
    .r_ppn0(r_ppn0), .r_plv0(r_plv0), .r_mat0(r_mat0), .r_d0(r_d0), .r_v0(r_v0),
    .r_ppn1(r_ppn1), .r_plv1(r_plv1), .r_mat1(r_mat1), .r_d1(r_d1), .r_v1(r_v1),
    .we(we), .w_index(w_index), .w_e(w_e), .w_vppn(w_vppn), .w_ps(w_ps),
    .w_asid(w_asid), .w_g(w_g),
    .w_ppn0(w_ppn0), .w_plv0(w_plv0), .w_mat0(w_mat0), .w_d0(w_d0), .w_v0(w_v0),
    .w_ppn1(w_ppn1), .w_plv1(w_plv1), .w_mat1(w_mat1), .w_d1(w_d1), .w_v1(w_v1),
    .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op)
  );

  always #5 clk = ~clk;

  // tlb read port
  assign r_e    = tlb[r_index].e;
  assign r_vppn = tlb[r_index].vppn;
  assign r_ps   = tlb[r_index].ps;
  assign r_asid = tlb[r_index].asid;
  assign r_g    = tlb[r_index].g;
  assign r_ppn0 = tlb[r_index].ppn0;
  assign r_ppn1 = tlb[r_index].ppn1;
  assign r_plv0 = tlb[r_index].plv0;
  assign r_plv1 = tlb[r_index].plv1;
  assign r_mat0 = tlb[r_index].mat0;
  assign r_mat1 = tlb[r_index].mat1;
  assign r_d0   = tlb[r_index].d0;
  assign r_d1   = tlb[r_index].d1;
  assign r_v0   = tlb[r_index].v0;
  assign r_v1   = tlb[r_index].v1;

  // tlb write port and fast-clear strobe
  always @(posedge clk) begin
    if (we) begin
      tlb[w_index] = '{e: w_e, vppn: w_vppn, ps: w_ps, asid: w_asid, g: w_g,
                       ppn0: w_ppn0, ppn1: w_ppn1, plv0: w_plv0, plv1: w_plv1,
                       mat0: w_mat0, mat1: w_mat1, d0: w_d0, d1: w_d1, v0: w_v0, v1: w_v1};
      we_cnt = we_cnt + 1;
    end
    if (invtlb_valid)
      for (int i = 0; i < 16; i++)
        if (invtlb_op == 5'd0 || tlb[i].g) tlb[i].e = 1'b0;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  function automatic bit is_fast(input logic [4:0] op);
`ifdef INVTLB_FAST_CLR_EN
    return op <= 5'd2;
`else
    return (op != op);
`endif
  endfunction

  // INVTLB match rules, straight from the op table
  function automatic bit mdl_hit(input logic [4:0] op, input ent_t t,
                                 input logic [9:0] asid, input logic [18:0] vppn);
    bit aeq, vm, h;
    int lo;
    aeq = (t.asid == asid);
    lo  = (int'(t.ps) > 12) ? int'(t.ps) - 12 : 0;
    vm  = 1'b1;
    for (int b = 0; b < 19; b++)
      if (b >= lo && t.vppn[b] != vppn[b]) vm = 1'b0;
    case (op)
      5'd0, 5'd1: h = 1'b1;
      5'd2:       h = t.g;
      5'd3:       h = !t.g;
      5'd4:       h = !t.g && aeq;
      5'd5:       h = !t.g && aeq && vm;
      5'd6:       h = (t.g || aeq) && vm;
      default:    h = 1'b0;
    endcase
    return t.e && h;
  endfunction

  // Model state: cycles since accept, expected writes and final table
  bit         chk_en = 1'b0;
  bit         mdl_active = 1'b0;
  int         cyc = 0;
  logic [4:0] m_op;
  bit [15:0]  hitvec;
  ent_t       exp_tbl [16];
  bit         e_ready, e_done, e_ine, e_we, e_iv, fin;
  logic [4:0] e_iop;

  always @(negedge clk) begin
    if (!resetn) begin
      mdl_active = 1'b0;
      cyc = 0;
      if (chk_en) begin
        chk("rst_ready", 128'(req_ready), 128'(1));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_we", 128'(we), 128'(0));
      end
    end else if (chk_en) begin
      if (mdl_active) cyc = cyc + 1;
      e_ready = !mdl_active;
      e_done = 0; e_ine = 0; e_we = 0; e_iv = 0; e_iop = '0; fin = 0;
      if (mdl_active) begin
        if (m_op > 5'd6) begin
          if (cyc == 1) begin e_done = 1; e_ine = 1; fin = 1; end
        end else if (is_fast(m_op)) begin
          if (cyc == 1) begin e_iv = 1; e_iop = (m_op == 5'd2) ? 5'd1 : 5'd0; end
          else if (cyc == 2) begin e_done = 1; fin = 1; end
        end else if (cyc <= 16) begin
          e_we = hitvec[cyc-1];
          chk("r_index", 128'(r_index), 128'(cyc - 1));
        end else begin
          e_done = 1; fin = 1;
        end
      end
      chk("req_ready", 128'(req_ready), 128'(e_ready));
      chk("busy", 128'(busy), 128'(!e_ready));
      chk("done", 128'(done), 128'(e_done));
      chk("ine", 128'(ine), 128'(e_ine));
      chk("we", 128'(we), 128'(e_we));
      chk("invtlb_valid", 128'(invtlb_valid), 128'(e_iv));
      chk("invtlb_op", 128'(invtlb_op), 128'(e_iop));
      if (e_we) chk("w_index", 128'(w_index), 128'(cyc - 1));
      if (fin) mdl_active = 1'b0;
      if (e_ready && req_valid) begin
        m_op = req_op;
        for (int i = 0; i < 16; i++) begin
          hitvec[i]  = (m_op <= 5'd6) && mdl_hit(req_op, tlb[i], req_asid, req_vppn);
          exp_tbl[i] = tlb[i];
          if (hitvec[i]) exp_tbl[i].e = 1'b0;
        end
        cyc = 0;
        mdl_active = 1'b1;
      end
    end
  end

  task automatic set_ent(input int i, input bit e, input bit g, input logic [9:0] a,
                         input logic [5:0] ps, input logic [18:0] vp);
    ent_t t;
    t = '0;
    t.ppn0 = 20'($urandom); t.ppn1 = 20'($urandom);
    t.plv0 = 2'($urandom);  t.plv1 = 2'($urandom);
    t.mat0 = 2'($urandom);  t.mat1 = 2'($urandom);
    t.d0 = 1'($urandom); t.d1 = 1'($urandom); t.v0 = 1'($urandom); t.v1 = 1'($urandom);
    t.e = e; t.g = g; t.asid = a; t.ps = ps; t.vppn = vp;
    tlb[i] = t;
  endtask

  task automatic fill_simple(input bit g);
    for (int i = 0; i < 16; i++) set_ent(i, 1'b1, g, 10'(i), 6'd12, 19'(i * 7));
  endtask

  task automatic fill_mixed();
    logic [5:0] ps;
    for (int i = 0; i < 16; i++) begin
      case (i % 4)
        0: ps = 6'd12;
        1: ps = 6'd13;
        2: ps = 6'd21;
        default: ps = 6'd30;
      endcase
      set_ent(i, i != 11, (i % 3) == 0, ((i % 2) != 0) ? 10'h55 : 10'h56, ps,
              19'h2A000 + 19'(i * 3));
    end
  endtask

  task automatic chk_tbl(input string nm);
    for (int i = 0; i < 16; i++) chk(nm, 128'(tlb[i]), 128'(exp_tbl[i]));
  endtask

  // One INVTLB transaction; rst_at>0 pulls resetn during the walk cycle after rst_at
  task automatic run_op(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] vppn,
                        input bit hold, input int rst_at, output int done_cyc, output bit ine_seen);
    int n;
    we_cnt = 0;
    done_cyc = -1;
    ine_seen = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_asid = asid; req_vppn = vppn;
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n = n + 1;
      if (done) begin done_cyc = n; ine_seen = ine; break; end
      if (hold && n == 5) begin req_op = 5'd7; req_asid = 10'h3FF; req_vppn = 19'h7FFFF; end
      if (rst_at > 0 && n == rst_at) begin
        @(posedge clk); #1 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
    if (rst_at == 0 && done_cyc < 0) chk("done_timeout", 128'(1), 128'(0));
    @(posedge clk); #1;
  endtask

  int dc;
  bit is;
  int nv;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    resetn = 1'b1; req_valid = 1'b0; req_op = '0; req_asid = '0; req_vppn = '0; we_cnt = 0;
    for (int i = 0; i < 16; i++) tlb[i] = '0;
    #2 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", 128'(req_ready), 128'(1));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_done", 128'(done), 128'(0));
    chk("reset_ine", 128'(ine), 128'(0));
    chk("reset_we", 128'(we), 128'(0));
    chk("reset_r_index", 128'(r_index), 128'(0));
    chk("reset_w_index", 128'(w_index), 128'(0));
    chk("reset_invtlb_valid", 128'(invtlb_valid), 128'(0));
    chk("reset_invtlb_op", 128'(invtlb_op), 128'(0));
    chk_en = 1'b1;

    // op0 on a fully valid table
    fill_simple(1'b0);
    tlb[4].g = 1'b1;
    run_op(5'd0, 10'h0, 19'h0, 1'b0, 0, dc, is);
`ifdef INVTLB_FAST_CLR_EN
    chk("op0_done_cycle", 128'(dc), 128'(2));
    chk("op0_we_count", 128'(we_cnt), 128'(0));
`else
    chk("op0_done_cycle", 128'(dc), 128'(17));
    chk("op0_we_count", 128'(we_cnt), 128'(16));
`endif
    nv = 0;
    for (int i = 0; i < 16; i++) nv = nv + int'(tlb[i].e);
    chk("op0_valid_left", 128'(nv), 128'(0));
    chk_tbl("op0_table");

    // op4: asid match on non-global entries only
    for (int i = 0; i < 16; i++) set_ent(i, 1'b0, 1'b0, 10'h12, 6'd12, 19'(i));
    set_ent(3, 1'b1, 1'b1, 10'h12, 6'd12, 19'h3);
    set_ent(5, 1'b1, 1'b0, 10'h12, 6'd12, 19'h5);
    set_ent(6, 1'b1, 1'b0, 10'h13, 6'd12, 19'h6);
    run_op(5'd4, 10'h12, 19'h0, 1'b0, 0, dc, is);
    chk("op4_e5", 128'(tlb[5].e), 128'(0));
    chk("op4_e3", 128'(tlb[3].e), 128'(1));
    chk("op4_e6", 128'(tlb[6].e), 128'(1));
    chk("op4_we_count", 128'(we_cnt), 128'(1));
    chk_tbl("op4_table");

    // op5: 2MB page ignores the low 9 VPPN bits; a 4KB page does not
    for (int i = 0; i < 16; i++) set_ent(i, 1'b0, 1'b0, 10'h34, 6'd12, 19'h10000);
    set_ent(7, 1'b1, 1'b0, 10'h34, 6'd21, 19'h10000);
    set_ent(9, 1'b1, 1'b0, 10'h34, 6'd12, 19'h10000);
    set_ent(10, 1'b1, 1'b0, 10'h34, 6'd21, 19'h10200);
    run_op(5'd5, 10'h34, 19'h101FF, 1'b0, 0, dc, is);
    chk("op5_e7", 128'(tlb[7].e), 128'(0));
    chk("op5_e9", 128'(tlb[9].e), 128'(1));
    chk("op5_e10", 128'(tlb[10].e), 128'(1));
    chk_tbl("op5_table");

    // undefined ops
    fill_simple(1'b0);
    run_op(5'd7, 10'h0, 19'h0, 1'b0, 0, dc, is);
    chk("op7_done_cycle", 128'(dc), 128'(1));
    chk("op7_ine", 128'(is), 128'(1));
    chk("op7_we_count", 128'(we_cnt), 128'(0));
    run_op(5'd31, 10'h0, 19'h0, 1'b0, 0, dc, is);
    chk("op31_ine", 128'(is), 128'(1));
    chk_tbl("op31_table");

    // all ops on a mixed table
    for (int k = 0; k < 7; k++) begin
      fill_mixed();
      run_op(5'(k), (k == 6) ? 10'h56 : 10'h55, 19'h2A000, 1'b0, 0, dc, is);
      chk("mixed_ine", 128'(is), 128'(0));
      chk_tbl("mixed_table");
    end
    fill_mixed();
    run_op(5'd6, 10'h55, 19'h2A001, 1'b0, 0, dc, is);
    chk_tbl("mixed_op6b_table");

    // request held high and operands changed while busy
    fill_simple(1'b0);
    run_op(5'd3, 10'h0, 19'h0, 1'b1, 0, dc, is);
    chk("hold_done_cycle", 128'(dc), 128'(17));
    chk("hold_we_count", 128'(we_cnt), 128'(16));
    chk_tbl("hold_table");

    // reset during walk at idx 8
    fill_simple(1'b0);
    run_op(5'd3, 10'h0, 19'h0, 1'b0, 8, dc, is);
    chk("rst_no_done", 128'(dc), 128'(-1));
    for (int i = 0; i < 16; i++) chk("rst_entry_e", 128'(tlb[i].e), 128'(i >= 8));
    run_op(5'd3, 10'h0, 19'h0, 1'b0, 0, dc, is);
    chk("post_rst_done_cycle", 128'(dc), 128'(17));
    chk_tbl("post_rst_table");

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
